// File: rtl/traffic_gen_burst_kernel.sv
// Paced request kernel: forwards beats from r_* to w_* through a single output register,
// pacing input acceptance as bursts of active cycles separated by idle gaps.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | waiting for start_i; ready_o high
// ST_REQ  | active phase, input accepted, cyc_q counts up to burst length
// ST_GAP  | idle phase, no input accepted, gap_q counts down to zero
// ST_DONE | single cycle after last beat issued; done_o pulses next cycle
module traffic_gen_burst_kernel #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_LEN    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [CNT_LEN-1:0]    n_total_reqs_i,
  input  logic [CNT_LEN-1:0]    t_ck_reqs_i,
  input  logic [CNT_LEN-1:0]    t_ck_idle_i,
  input  logic                  r_valid_i,
  output logic                  r_ready_o,
  input  logic [DATA_WIDTH-1:0] r_data_i,
  output logic                  w_valid_o,
  input  logic                  w_ready_i,
  output logic [DATA_WIDTH-1:0] w_data_o,
  output logic                  done_o,
  output logic                  ready_o,
  output logic                  idle_o,
  output logic [CNT_LEN-1:0]    cnt_issued_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP, ST_DONE} state_e;

  state_e                state_q, state_d;
  logic [CNT_LEN-1:0]    n_total_q, n_total_d;
  logic [CNT_LEN-1:0]    t_reqs_q, t_reqs_d;
  logic [CNT_LEN-1:0]    t_idle_q, t_idle_d;
  logic [CNT_LEN-1:0]    cyc_q, cyc_d;
  logic [CNT_LEN-1:0]    gap_q, gap_d;
  logic [CNT_LEN-1:0]    accepted_q, accepted_d;
  logic [CNT_LEN-1:0]    cnt_issued_q, cnt_issued_d;
  logic                  w_valid_q, w_valid_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic                  done_q, done_d;
  logic                  r_ready, r_hs, w_hs;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      n_total_q    <= '0;
      t_reqs_q     <= '0;
      t_idle_q     <= '0;
      cyc_q        <= '0;
      gap_q        <= '0;
      accepted_q   <= '0;
      cnt_issued_q <= '0;
      w_valid_q    <= 1'b0;
      w_data_q     <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_total_q    <= n_total_d;
      t_reqs_q     <= t_reqs_d;
      t_idle_q     <= t_idle_d;
      cyc_q        <= cyc_d;
      gap_q        <= gap_d;
      accepted_q   <= accepted_d;
      cnt_issued_q <= cnt_issued_d;
      w_valid_q    <= w_valid_d;
      w_data_q     <= w_data_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    n_total_d    = n_total_q;
    t_reqs_d     = t_reqs_q;
    t_idle_d     = t_idle_q;
    cyc_d        = cyc_q;
    gap_d        = gap_q;
    accepted_d   = accepted_q;
    cnt_issued_d = cnt_issued_q;
    w_valid_d    = w_valid_q;
    w_data_d     = w_data_q;
    done_d       = (state_q == ST_DONE);
    r_ready      = 1'b0;

    // Gating with clear_i keeps upstream from losing a beat into an aborted run.
    if (state_q == ST_REQ) begin
      r_ready = (~w_valid_q | w_ready_i) & (accepted_q < n_total_q) & ~clear_i;
    end
    r_hs = r_ready & r_valid_i;
    w_hs = w_valid_q & w_ready_i;

    if (w_hs) begin
      w_valid_d    = 1'b0;
      cnt_issued_d = cnt_issued_q + CNT_LEN'(1);
    end
    if (r_hs) begin
      w_valid_d  = 1'b1;
      w_data_d   = r_data_i;
      accepted_d = accepted_q + CNT_LEN'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          n_total_d    = n_total_reqs_i;
          t_reqs_d     = (t_ck_reqs_i == '0) ? CNT_LEN'(1) : t_ck_reqs_i;
          t_idle_d     = t_ck_idle_i;
          cyc_d        = '0;
          gap_d        = '0;
          accepted_d   = '0;
          cnt_issued_d = '0;
          state_d      = (n_total_reqs_i == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (cyc_q == t_reqs_q - CNT_LEN'(1)) begin
          cyc_d = '0;
          if (t_idle_q != '0) begin
            gap_d   = t_idle_q - CNT_LEN'(1);
            state_d = ST_GAP;
          end
        end else begin
          cyc_d = cyc_q + CNT_LEN'(1);
        end
        if (cnt_issued_d == n_total_q) state_d = ST_DONE;
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          cyc_d   = '0;
          state_d = ST_REQ;
        end else begin
          gap_d = gap_q - CNT_LEN'(1);
        end
        if (cnt_issued_d == n_total_q) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (clear_i) begin
      state_d      = ST_IDLE;
      w_valid_d    = 1'b0;
      cyc_d        = '0;
      gap_d        = '0;
      accepted_d   = '0;
      cnt_issued_d = '0;
      done_d       = 1'b0;
    end
  end

  assign r_ready_o    = r_ready;
  assign w_valid_o    = w_valid_q;
  assign w_data_o     = w_data_q;
  assign done_o       = done_q;
  assign ready_o      = (state_q == ST_IDLE);
  assign idle_o       = (state_q == ST_IDLE) & ~w_valid_q;
  assign cnt_issued_o = cnt_issued_q;

endmodule

// File: tb/tb_traffic_gen_burst_kernel.sv
// Directed bench for traffic_gen_burst_kernel: pacing, back-pressure, degenerate
// parameters, abort, ignored start and async reset, input starvation.
module tb_traffic_gen_burst_kernel;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear, start;
  logic [31:0] n_total, t_reqs, t_idle;
  logic        r_valid, r_ready_o;
  logic [31:0] r_data;
  logic        w_valid_o, w_ready;
  logic [31:0] w_data_o;
  logic        done_o, ready_o, idle_o;
  logic [31:0] cnt_issued_o;

  int n_cmp = 0;
  int n_err = 0;

  int          cyc_n, n_done, done_cyc, n_w, n_wv, stab_viol;
  logic [31:0] base, src_idx;
  logic        rr [0:127];
  logic [31:0] wbeats [0:63];
  logic        stall_q;
  logic [31:0] stall_data;

  traffic_gen_burst_kernel dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .clear_i        (clear),
    .start_i        (start),
    .n_total_reqs_i (n_total),
    .t_ck_reqs_i    (t_reqs),
    .t_ck_idle_i    (t_idle),
    .r_valid_i      (r_valid),
    .r_ready_o      (r_ready_o),
    .r_data_i       (r_data),
    .w_valid_o      (w_valid_o),
    .w_ready_i      (w_ready),
    .w_data_o       (w_data_o),
    .done_o         (done_o),
    .ready_o        (ready_o),
    .idle_o         (idle_o),
    .cnt_issued_o   (cnt_issued_o)
  );

  always #5 clk = ~clk;

  // One clock: observe handshakes at the falling edge, then advance the source after the rising edge.
  task automatic step();
    logic rhs;
    @(negedge clk);
    rhs = r_valid && r_ready_o;
    if (cyc_n < 128) rr[cyc_n] = r_ready_o;
    if (w_valid_o) n_wv++;
    if (w_valid_o && w_ready) begin
      if (n_w < 64) wbeats[n_w] = w_data_o;
      n_w++;
    end
    if (done_o) begin
      n_done++;
      done_cyc = cyc_n;
    end
    if (stall_q && (!w_valid_o || w_data_o !== stall_data)) stab_viol++;
    stall_q    = w_valid_o && !w_ready;
    stall_data = w_data_o;
    cyc_n++;
    @(posedge clk);
    #1;
    if (rhs) src_idx++;
    r_data = base + src_idx;
  endtask

  task automatic kick(input logic [31:0] n, input logic [31:0] rq, input logic [31:0] id,
                      input logic [31:0] b);
    n_total = n; t_reqs = rq; t_idle = id;
    base = b; src_idx = 0; r_data = b;
    n_w = 0; n_wv = 0; n_done = 0; done_cyc = -1; cyc_n = 0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    for (int k = 0; k < budget && n_done == 0; k++) step();
  endtask

  task automatic test_reset();
    n_cmp++; if (w_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_w_valid got %b want 0", w_valid_o); end
    n_cmp++; if (w_data_o !== 32'h0) begin n_err++; $display("FAIL reset_w_data got %h want 0", w_data_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done_o); end
    n_cmp++; if (cnt_issued_o !== 32'h0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", cnt_issued_o); end
    n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", ready_o); end
    n_cmp++; if (idle_o !== 1'b1) begin n_err++; $display("FAIL reset_idle got %b want 1", idle_o); end
    n_cmp++; if (r_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_r_ready got %b want 0", r_ready_o); end
  endtask

  task automatic test_basic();
    logic [15:0] v;
    kick(8, 4, 3, 32'hA0);
    run_to_done(80);
    for (int k = 0; k < 3; k++) step();
    n_cmp++; if (n_w !== 8) begin n_err++; $display("FAIL basic_beats got %0d want 8", n_w); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (wbeats[i] !== 32'hA0 + i) begin n_err++; $display("FAIL basic_data[%0d] got %h want %h", i, wbeats[i], 32'hA0 + i); end
    end
    v = '0;
    for (int i = 1; i <= 12; i++) v = {v[14:0], rr[i]};
    n_cmp++; if (v[11:0] !== 12'b1111_0001_1110) begin n_err++; $display("FAIL basic_pacing got %b want 111100011110", v[11:0]); end
    n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL basic_done_count got %0d want 1", n_done); end
    n_cmp++; if (done_cyc !== 14) begin n_err++; $display("FAIL basic_done_cycle got %0d want 14", done_cyc); end
    n_cmp++; if (cnt_issued_o !== 32'd8) begin n_err++; $display("FAIL basic_cnt got %0d want 8", cnt_issued_o); end
  endtask

  task automatic test_backpressure();
    stab_viol = 0; stall_q = 1'b0;
    kick(4, 8, 0, 32'hB0);
    for (int k = 0; k < 60 && n_done == 0; k++) begin
      w_ready = ~w_ready;
      step();
    end
    w_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    n_cmp++; if (n_w !== 4) begin n_err++; $display("FAIL bp_beats got %0d want 4", n_w); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (wbeats[i] !== 32'hB0 + i) begin n_err++; $display("FAIL bp_data[%0d] got %h want %h", i, wbeats[i], 32'hB0 + i); end
    end
    n_cmp++; if (stab_viol !== 0) begin n_err++; $display("FAIL bp_stable got %0d violations want 0", stab_viol); end
    n_cmp++; if (cnt_issued_o !== 32'd4) begin n_err++; $display("FAIL bp_cnt got %0d want 4", cnt_issued_o); end
    n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL bp_done_count got %0d want 1", n_done); end
  endtask

  task automatic test_degenerate();
    logic [15:0] v;
    kick(0, 4, 3, 32'hC0);
    for (int k = 0; k < 4; k++) step();
    n_cmp++; if (done_cyc !== 2) begin n_err++; $display("FAIL n0_done_cycle got %0d want 2", done_cyc); end
    n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL n0_done_count got %0d want 1", n_done); end
    n_cmp++; if (n_wv !== 0) begin n_err++; $display("FAIL n0_w_valid got %0d cycles want 0", n_wv); end

    kick(3, 0, 2, 32'hD0);
    run_to_done(60);
    v = '0;
    for (int i = 1; i <= 8; i++) v = {v[14:0], rr[i]};
    n_cmp++; if (v[7:0] !== 8'b1001_0010) begin n_err++; $display("FAIL reqs0_pacing got %b want 10010010", v[7:0]); end
    n_cmp++; if (n_w !== 3) begin n_err++; $display("FAIL reqs0_beats got %0d want 3", n_w); end

    kick(6, 2, 0, 32'hE0);
    run_to_done(60);
    v = '0;
    for (int i = 1; i <= 7; i++) v = {v[14:0], rr[i]};
    n_cmp++; if (v[6:0] !== 7'b1111110) begin n_err++; $display("FAIL idle0_stream got %b want 1111110", v[6:0]); end
    n_cmp++; if (n_w !== 6) begin n_err++; $display("FAIL idle0_beats got %0d want 6", n_w); end
  endtask

  task automatic test_abort();
    kick(10, 4, 3, 32'h300);
    for (int k = 0; k < 20 && cnt_issued_o != 32'd3; k++) step();
    n_cmp++; if (cnt_issued_o !== 32'd3) begin n_err++; $display("FAIL abort_reach got %0d want 3", cnt_issued_o); end
    w_ready = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_cmp++; if (idle_o !== 1'b1) begin n_err++; $display("FAIL abort_idle got %b want 1", idle_o); end
    n_cmp++; if (w_valid_o !== 1'b0) begin n_err++; $display("FAIL abort_w_valid got %b want 0", w_valid_o); end
    n_cmp++; if (cnt_issued_o !== 32'd0) begin n_err++; $display("FAIL abort_cnt got %0d want 0", cnt_issued_o); end
    w_ready = 1'b1;
    n_done = 0;
    for (int k = 0; k < 4; k++) step();
    n_cmp++; if (n_done !== 0) begin n_err++; $display("FAIL abort_no_done got %0d want 0", n_done); end

    kick(10, 4, 3, 32'h400);
    run_to_done(100);
    n_cmp++; if (n_w !== 10) begin n_err++; $display("FAIL restart_beats got %0d want 10", n_w); end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (wbeats[i] !== 32'h400 + i) begin n_err++; $display("FAIL restart_data[%0d] got %h want %h", i, wbeats[i], 32'h400 + i); end
    end
    n_cmp++; if (cnt_issued_o !== 32'd10) begin n_err++; $display("FAIL restart_cnt got %0d want 10", cnt_issued_o); end
  endtask

  task automatic test_ignored_start_reset();
    kick(8, 4, 3, 32'h100);
    step();
    start = 1'b1; n_total = 2; t_reqs = 1; t_idle = 0;
    step();
    start = 1'b0;
    run_to_done(80);
    for (int k = 0; k < 3; k++) step();
    n_cmp++; if (n_w !== 8) begin n_err++; $display("FAIL ign_beats got %0d want 8", n_w); end
    n_cmp++; if (cnt_issued_o !== 32'd8) begin n_err++; $display("FAIL ign_cnt got %0d want 8", cnt_issued_o); end
    n_cmp++; if (done_cyc !== 14) begin n_err++; $display("FAIL ign_done_cycle got %0d want 14", done_cyc); end

    kick(8, 4, 3, 32'h200);
    for (int k = 0; k < 4; k++) step();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (w_valid_o !== 1'b0) begin n_err++; $display("FAIL arst_w_valid got %b want 0", w_valid_o); end
    n_cmp++; if (w_data_o !== 32'h0) begin n_err++; $display("FAIL arst_w_data got %h want 0", w_data_o); end
    n_cmp++; if (cnt_issued_o !== 32'h0) begin n_err++; $display("FAIL arst_cnt got %0d want 0", cnt_issued_o); end
    n_cmp++; if (ready_o !== 1'b1 || idle_o !== 1'b1) begin n_err++; $display("FAIL arst_ready_idle got %b%b want 11", ready_o, idle_o); end
    n_cmp++; if (r_ready_o !== 1'b0) begin n_err++; $display("FAIL arst_r_ready got %b want 0", r_ready_o); end
    #2;
    rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 4; k++) step();
    n_cmp++; if (n_done !== 0) begin n_err++; $display("FAIL arst_no_done got %0d want 0", n_done); end
  endtask

  task automatic test_starvation();
    r_valid = 1'b0;
    kick(3, 2, 2, 32'h500);
    for (int k = 0; k < 60 && n_done == 0; k++) begin
      r_valid = (cyc_n >= 5);
      step();
    end
    r_valid = 1'b1;
    for (int k = 0; k < 3; k++) step();
    n_cmp++; if (done_cyc !== 12) begin n_err++; $display("FAIL starve_done_cycle got %0d want 12", done_cyc); end
    n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL starve_done_count got %0d want 1", n_done); end
    n_cmp++; if (n_w !== 3) begin n_err++; $display("FAIL starve_beats got %0d want 3", n_w); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (wbeats[i] !== 32'h500 + i) begin n_err++; $display("FAIL starve_data[%0d] got %h want %h", i, wbeats[i], 32'h500 + i); end
    end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; start = 1'b0;
    n_total = '0; t_reqs = '0; t_idle = '0;
    r_valid = 1'b1; r_data = '0; w_ready = 1'b1;
    base = '0; src_idx = '0; stall_q = 1'b0; stall_data = '0;
    cyc_n = 0; n_done = 0; done_cyc = -1; n_w = 0; n_wv = 0; stab_viol = 0;
    #3;
    test_reset();
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_basic();
    test_backpressure();
    test_degenerate();
    test_abort();
    test_ignored_start_reset();
    test_starvation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
